bin2bcd_seq: RTL and testbench

BIN2BCD_SEQ -- requirements
Module: bin2bcd_seq

---
 rtl/bin2bcd_seq.sv | 102 ++++++++++
 tb/tb_bin2bcd_seq.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/bin2bcd_seq.sv
// rtl/bin2bcd_seq.sv - sequential double-dabble binary to BCD converter
module bin2bcd_seq #(
    parameter int WIDTH  = 20,
    parameter int DIGITS = 6
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [WIDTH-1:0] value,
    output logic             busy,
    output logic             done,
    output logic             overflow,
    output logic [3:0]       bcd0,
    output logic [3:0]       bcd1,
    output logic [3:0]       bcd2,
    output logic [3:0]       bcd3,
    output logic [3:0]       bcd4,
    output logic [3:0]       bcd5
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam int BW = 4 * DIGITS;
    localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(10 ** DIGITS - 1);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t          state;
    logic [CW-1:0]   cnt;
    logic [WIDTH-1:0] operand;
    logic [BW-1:0]   scratch;
    logic            sat;
    logic [BW-1:0]   digits;

    logic [BW-1:0]   dabbled;
    logic [BW-1:0]   shifted;
    logic [BW-1:0]   nines;

    always_comb begin
        dabbled = scratch;
        nines   = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (scratch[4*i +: 4] >= 4'd5)
                dabbled[4*i +: 4] = scratch[4*i +: 4] + 4'd3;
            nines[4*i +: 4] = 4'd9;
        end
        // The carry out of the top nibble is dropped; it cannot occur in range.
        shifted = {dabbled[BW-2:0], operand[WIDTH-1]};
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            cnt      <= '0;
            operand  <= '0;
            scratch  <= '0;
            sat      <= 1'b0;
            digits   <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            overflow <= 1'b0;
        end else begin
            done <= 1'b0;
            if (state == IDLE) begin
                if (start) begin
                    operand <= value;
                    cnt     <= CW'(WIDTH);
                    scratch <= '0;
                    sat     <= (value > MAX_VAL);
                    busy    <= 1'b1;
                    state   <= SHIFT;
                end
            end else begin
                scratch <= shifted;
                operand <= {operand[WIDTH-2:0], 1'b0};
                cnt     <= cnt - 1'b1;
                if (cnt == CW'(1)) begin
                    done     <= 1'b1;
                    overflow <= sat;
                    digits   <= sat ? nines : shifted;
                    // A start on the final step edge re-arms at once for a WIDTH-cycle period.
                    if (start) begin
                        operand <= value;
                        cnt     <= CW'(WIDTH);
                        scratch <= '0;
                        sat     <= (value > MAX_VAL);
                    end else begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
            end
        end
    end

    assign bcd0 = digits[3:0];
    assign bcd1 = digits[7:4];
    assign bcd2 = digits[11:8];
    assign bcd3 = digits[15:12];
    assign bcd4 = digits[19:16];
    assign bcd5 = digits[23:20];

endmodule

// File: tb/tb_bin2bcd_seq.sv
// tb/tb_bin2bcd_seq.sv - scoreboard bench for bin2bcd_seq
module tb_bin2bcd_seq;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic [19:0] value = '0;
    logic        busy, done, overflow;
    logic [3:0]  bcd0, bcd1, bcd2, bcd3, bcd4, bcd5;

    bin2bcd_seq #(.WIDTH(20), .DIGITS(6)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .value(value),
        .busy(busy), .done(done), .overflow(overflow),
        .bcd0(bcd0), .bcd1(bcd1), .bcd2(bcd2), .bcd3(bcd3), .bcd4(bcd4), .bcd5(bcd5)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [23:0] d;
        logic        ovf;
        int          cyc;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          done_count = 0;
    logic [23:0] last_d = '0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [23:0] model(input int unsigned v);
        logic [23:0] r;
        if (v > 999999) return 24'h999999;
        for (int i = 0; i < 6; i++) begin
            r[4*i +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return r;
    endfunction

    function automatic logic [23:0] dig();
        return {bcd5, bcd4, bcd3, bcd2, bcd1, bcd0};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (reset_n && done) begin
            done_count++;
            if (sb.size() == 0) begin
                check("unexpected_done", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("digits", {8'h0, dig()}, {8'h0, e.d});
                check("overflow", {31'h0, overflow}, {31'h0, e.ovf});
                check("done_cycle", cyc, e.cyc);
                last_d = e.d;
            end
        end
    end

    task automatic push_exp(input int unsigned v);
        exp_t e;
        e.d   = model(v);
        e.ovf = (v > 999999);
        e.cyc = cyc + 1 + 20;
        sb.push_back(e);
    endtask

    task automatic conv(input int unsigned v);
        @(negedge clk);
        start = 1'b1;
        value = 20'(v);
        push_exp(v);
        @(negedge clk);
        start = 1'b0;
        check("busy_after_start", {31'h0, busy}, 32'd1);
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 80 && sb.size() != 0; i++) begin
            @(negedge clk);
            #2;
        end
        if (sb.size() != 0) begin
            check("done_timeout", sb.size(), 32'd0);
            sb.delete();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        repeat (3) @(negedge clk);
        check("reset_busy", {31'h0, busy}, 32'd0);
        check("reset_done", {31'h0, done}, 32'd0);
        check("reset_ovf", {31'h0, overflow}, 32'd0);
        check("reset_digits", {8'h0, dig()}, 32'd0);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);

        conv(0);       wait_idle();
        conv(123456);  wait_idle();
        conv(999999);
        repeat (10) @(negedge clk);
        check("hold_between_done", {8'h0, dig()}, 32'h123456);
        wait_idle();
        conv(1000000); wait_idle();
        conv(42);      wait_idle();
        check("busy_after_done", {31'h0, busy}, 32'd0);

        base = done_count;
        conv(500);
        repeat (4) @(negedge clk);
        start = 1'b1;
        value = 20'd777;
        @(negedge clk);
        start = 1'b0;
        wait_idle();
        repeat (25) @(negedge clk);
        check("ignore_start_in_shift", done_count - base, 32'd1);
        check("hold_500", {8'h0, dig()}, 32'h000500);

        base = done_count;
        conv(12);
        repeat (9) @(negedge clk);
        reset_n = 1'b0;
        #1;
        check("async_reset_digits", {8'h0, dig()}, 32'd0);
        check("async_reset_busy", {31'h0, busy}, 32'd0);
        sb.delete();
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        repeat (25) @(negedge clk);
        check("no_done_after_abort", done_count - base, 32'd0);
        conv(31415);   wait_idle();

        base = done_count;
        @(negedge clk);
        for (int v = 1; v <= 3; v++) begin
            start = 1'b1;
            value = 20'(v);
            push_exp(v);
            if (v < 3) repeat (20) @(negedge clk);
        end
        @(negedge clk);
        start = 1'b0;
        check("busy_back_to_back", {31'h0, busy}, 32'd1);
        wait_idle();
        repeat (25) @(negedge clk);
        check("back_to_back_count", done_count - base, 32'd3);
        check("final_hold", {8'h0, dig()}, {8'h0, last_d});

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
